cht_shift_seq: RTL and testbench

Sequencer and two-port arbiter for the cht single-position shift/select datapath. It accepts shift commands from two requesters and grants them round-robin. Each command is executed as a chain of one-position passes through the external combinational cht network, with the controller driving the network's select lines and feeding back the working word each cycle. The result is returned on a valid/ready response port tagged with the requester id.

---
 rtl/cht_shift_seq_pkg.sv | 21 ++
 rtl/cht_shift_seq_if.sv | 37 +++
 rtl/cht_rr_arb2.sv | 32 +++
 rtl/cht_shift_seq.sv | 124 ++++++++++++
 tb/tb_cht_shift_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cht_shift_seq_pkg.sv
// Shared types and constants for the cht shift sequencer.
// Select vectors are ordered {l,k,j,p,i} to match the cht network pins.
package cht_shift_seq_pkg;

  localparam int CHT_DATA_W = 16;
  localparam int CHT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [4:0] sel_t;

  // l: pass-through, j: one position toward bit 0, k: one position toward MSB
  localparam sel_t SEL_HOLD  = 5'b10000;
  localparam sel_t SEL_RIGHT = 5'b00100;
  localparam sel_t SEL_LEFT  = 5'b01000;

endpackage

// File: rtl/cht_shift_seq_if.sv
// Command/response bundle between the requesters/consumer and cht_shift_seq.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The valid side holds valid and payload stable until it sees
// ready; dropping valid before ready is allowed and simply means no transfer.
// ready may depend combinationally on valid. rsp_* follows the same rules
// with the sequencer as the valid side.
interface cht_shift_seq_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
);

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][DATA_W-1:0] req_data;
  logic [1:0][CNT_W-1:0]  req_amt;
  logic [1:0]             req_dir;
  logic [1:0]             req_fill;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_id;

  // Requesters plus response consumer
  modport master (
    output req_valid, req_data, req_amt, req_dir, req_fill, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_data, req_amt, req_dir, req_fill, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/cht_rr_arb2.sv
// Two-input round-robin arbiter. When both inputs are valid the prio index
// wins; every grant moves prio to the other index, even an uncontested one.
module cht_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant,
  output logic       gnt_idx
);

  logic prio;

  // Pick the winner and gate the one-hot grant with enable
  always_comb begin
    gnt_idx = (valid == 2'b11) ? prio : valid[1];
    grant   = 2'b00;
    if (en && (valid != 2'b00)) begin
      grant = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  // Hand priority to the loser after each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (grant != 2'b00) begin
      prio <= ~gnt_idx;
    end
  end

endmodule

// File: rtl/cht_shift_seq.sv
// Sequencer for the cht single-position shift network. Commands from two
// requesters are arbitrated round-robin; each command runs as amt passes
// through the external network, feeding dp_dout back into the working word.
// Optional macro CHT_SHIFT_SEQ_STATS_EN adds the stat_cmds response counter.
module cht_shift_seq
  import cht_shift_seq_pkg::*;
#(
  parameter int DATA_W = CHT_DATA_W,
  parameter int CNT_W  = CHT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  cht_shift_seq_if.slave    bus,
  output logic [DATA_W-1:0] dp_din,
  output logic              dp_fill,
  output sel_t              dp_sel,
  input  logic [DATA_W-1:0] dp_dout,
  output state_t            dbg_state
`ifdef CHT_SHIFT_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_cmds
`endif
);

  state_t            state;
  logic [DATA_W-1:0] work;
  logic [CNT_W-1:0]  cnt;
  logic              fill_q;
  logic              id_q;
  logic              rsp_valid_q;
  sel_t              sel_q;

  logic [1:0]        grant;
  logic              gnt_idx;
  logic              accept;

  cht_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (bus.req_valid),
    .en      (state == IDLE),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  // Grant is already qualified by valid, so any grant is an accept
  assign accept        = (grant != 2'b00);
  assign bus.req_ready = grant;

  // Control FSM; select lines and response valid are registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      work        <= '0;
      cnt         <= '0;
      fill_q      <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      sel_q       <= SEL_HOLD;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work   <= bus.req_data[gnt_idx];
            cnt    <= bus.req_amt[gnt_idx];
            fill_q <= bus.req_fill[gnt_idx];
            id_q   <= gnt_idx;
            if (bus.req_amt[gnt_idx] != '0) begin
              state <= SHIFT;
              sel_q <= bus.req_dir[gnt_idx] ? SEL_LEFT : SEL_RIGHT;
            end else begin
              state       <= DONE;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= dp_dout;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= DONE;
            sel_q       <= SEL_HOLD;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          sel_q       <= SEL_HOLD;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign dp_din        = work;
  assign dp_fill       = fill_q;
  assign dp_sel        = sel_q;
  assign dbg_state     = state;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = work;
  assign bus.rsp_id    = id_q;

`ifdef CHT_SHIFT_SEQ_STATS_EN
  logic [15:0] stat_q;

  // Count completed response handshakes, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= 16'h0000;
    end else if (rsp_valid_q && bus.rsp_ready && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'h0001;
    end
  end

  assign stat_cmds = stat_q;
`endif

endmodule

// File: tb/tb_cht_shift_seq.sv
// Self-checking bench for cht_shift_seq with a behavioural cht network.
module tb_cht_shift_seq;
  import cht_shift_seq_pkg::*;

  localparam logic [4:0] HOLD  = 5'b10000;
  localparam logic [4:0] RIGHT = 5'b00100;
  localparam logic [4:0] LEFT  = 5'b01000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  cht_shift_seq_if #(.DATA_W(16), .CNT_W(4)) bus ();

  logic [15:0] dp_din;
  logic        dp_fill;
  logic [4:0]  dp_sel;
  logic [15:0] dp_dout;
  state_t      dbg_state;
`ifdef CHT_SHIFT_SEQ_STATS_EN
  logic [15:0] stat_cmds;
`endif

  cht_shift_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dp_din    (dp_din),
    .dp_fill   (dp_fill),
    .dp_sel    (dp_sel),
    .dp_dout   (dp_dout),
    .dbg_state (dbg_state)
`ifdef CHT_SHIFT_SEQ_STATS_EN
    ,
    .stat_cmds (stat_cmds)
`endif
  );

  // Behavioural cht network; unknown selects corrupt the word visibly
  always_comb begin
    case (dp_sel)
      5'b10000: dp_dout = dp_din;
      5'b00100: dp_dout = {dp_fill, dp_din[15:1]};
      5'b01000: dp_dout = {dp_din[14:0], dp_fill};
      default:  dp_dout = ~dp_din;
    endcase
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_shift(logic [15:0] d, int a, logic dr, logic f);
    for (int i = 0; i < a; i++) d = dr ? {d[14:0], f} : {f, d[15:1]};
    return d;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [16:0] exp_q[$];     // {id, data}
  int          cyc_q[$];     // cycle in which rsp_valid must first rise
  logic        grant_log[$]; // granted index as seen on req_ready
  int          acc_log[$];   // accept cycles

  logic        busy = 1'b0;
  logic        tb_prio = 1'b0;
  int          rem = 0;
  logic        cur_dir = 1'b0;
  logic        cur_fill = 1'b0;
  int          hs_cnt = 0;
  int          last_acc = 0;
  int          last_lat = 0;
  logic [15:0] last_data = '0;
  logic        last_id = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic       g;
    logic [16:0] e;
    if (!rst_n) begin
      exp_q.delete();
      cyc_q.delete();
      busy = 1'b0; tb_prio = 1'b0; rem = 0; hs_cnt = 0;
      prev_valid = 1'b0; prev_ready = 1'b0;
    end else begin
      exp_rdy = 2'b00;
      g = (bus.req_valid == 2'b11) ? tb_prio : bus.req_valid[1];
      if (!busy && bus.req_valid != 2'b00) exp_rdy = g ? 2'b10 : 2'b01;
      check("req_ready", bus.req_ready, exp_rdy);

      if (busy && rem > 0) begin
        check("dp_sel_shift", dp_sel, cur_dir ? LEFT : RIGHT);
        rem--;
      end else begin
        check("dp_sel_hold", dp_sel, HOLD);
      end
      if (busy) check("dp_fill", dp_fill, cur_fill);

      if (bus.rsp_valid && !prev_valid) begin
        if (cyc_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          check("rsp_latency", cyc, cyc_q[0]);
          last_lat = cyc - last_acc;
        end
      end
      if (prev_valid && !prev_ready) begin
        check("rsp_hold_valid", bus.rsp_valid, 1);
        check("rsp_hold_data", bus.rsp_data, prev_data);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          void'(cyc_q.pop_front());
          check("rsp_data", bus.rsp_data, e[15:0]);
          check("rsp_id", bus.rsp_id, e[16]);
        end
        last_data = bus.rsp_data;
        last_id   = bus.rsp_id;
        busy = 1'b0;
        hs_cnt++;
      end

      if ((bus.req_valid & bus.req_ready) != 2'b00) begin
        grant_log.push_back(bus.req_ready[1]);
        acc_log.push_back(cyc);
      end
      if (exp_rdy != 2'b00) begin
        exp_q.push_back({g, model_shift(bus.req_data[g], int'(bus.req_amt[g]),
                                        bus.req_dir[g], bus.req_fill[g])});
        cyc_q.push_back(cyc + int'(bus.req_amt[g]) + 1);
        busy = 1'b1;
        rem = int'(bus.req_amt[g]);
        cur_dir = bus.req_dir[g];
        cur_fill = bus.req_fill[g];
        tb_prio = ~g;
        last_acc = cyc;
      end
      prev_valid = bus.rsp_valid;
      prev_ready = bus.rsp_ready;
      prev_data  = bus.rsp_data;
    end
  end

  // ---------------- response-ready driver ----------------
  int rdy_mode = 0; // 0 high, 1 low, 2 random

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int r, input logic [15:0] d, input logic [3:0] a,
                      input logic dr, input logic f);
    int n;
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b1;
    bus.req_data[r]  = d;
    bus.req_amt[r]   = a;
    bus.req_dir[r]   = dr;
    bus.req_fill[r]  = f;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready[r]) break;
      if (++n > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      if (!busy && exp_q.size() == 0) break;
      if (++n > 2000) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_dp_sel"}, dp_sel, HOLD);
    check({tag, "_dp_din"}, dp_din, 0);
    check({tag, "_dp_fill"}, dp_fill, 0);
    check({tag, "_state"}, dbg_state, IDLE);
`ifdef CHT_SHIFT_SEQ_STATS_EN
    check({tag, "_stat_cmds"}, stat_cmds, 0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] held;
    int n;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_data  = '0;
    bus.req_amt   = '0;
    bus.req_dir   = 2'b00;
    bus.req_fill  = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Right shift by 3
    send(0, 16'h8001, 4'd3, 1'b0, 1'b0);
    wait_idle();
    check("t1_data", last_data, 16'h1000);
    check("t1_id", last_id, 0);
    check("t1_latency", last_lat, 4);

    // Left shift by 1 with fill 1
    send(1, 16'h8001, 4'd1, 1'b1, 1'b1);
    wait_idle();
    check("t2_data", last_data, 16'h0003);
    check("t2_id", last_id, 1);
    check("t2_latency", last_lat, 2);

    // Zero passes
    send(0, 16'h1234, 4'd0, 1'b0, 1'b1);
    wait_idle();
    check("t3_data", last_data, 16'h1234);
    check("t3_latency", last_lat, 1);

    // Maximum pass count
    send(1, 16'hC3A5, 4'd15, 1'b0, 1'b1);
    wait_idle();
    check("tmax_latency", last_lat, 16);

    // Both requesters contend continuously from reset
    do_reset();
    grant_log.delete();
    acc_log.delete();
    @(posedge clk);
    #1;
    bus.req_data[0] = 16'h00F0; bus.req_amt[0] = 4'd2; bus.req_dir[0] = 1'b0; bus.req_fill[0] = 1'b1;
    bus.req_data[1] = 16'h0F00; bus.req_amt[1] = 4'd2; bus.req_dir[1] = 1'b1; bus.req_fill[1] = 1'b0;
    bus.req_valid = 2'b11;
    n = 0;
    forever begin
      @(posedge clk);
      if (grant_log.size() >= 4) break;
      if (++n > 100) begin
        check("rr_timeout", 0, 1);
        break;
      end
    end
    #1 bus.req_valid = 2'b00;
    wait_idle();
    check("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("rr_grant%0d", i), grant_log[i], i % 2);
    for (int i = 1; i < 4 && i < acc_log.size(); i++)
      check($sformatf("rr_gap%0d", i), acc_log[i] - acc_log[i-1], 4);

    // Consumer stalls in DONE for 10 cycles while requester 1 waits
    rdy_mode = 1;
    send(0, 16'hA5A5, 4'd1, 1'b1, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_rsp_valid", bus.rsp_valid, 1);
    held = bus.rsp_data;
    @(posedge clk);
    #1;
    bus.req_data[1] = 16'h5A5A; bus.req_amt[1] = 4'd2; bus.req_dir[1] = 1'b0; bus.req_fill[1] = 1'b0;
    bus.req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data", bus.rsp_data, held);
      check("stall_ready", bus.req_ready, 2'b00);
    end
    @(posedge clk);
    #1 rdy_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("release_idle", dbg_state, IDLE);
    check("release_grant", bus.req_ready, 2'b10);
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    wait_idle();

    // Reset in the middle of a long command
    do_reset();
    send(0, 16'hFFFF, 4'd15, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    send(1, 16'h0180, 4'd4, 1'b0, 1'b0);
    wait_idle();
    check("post_rst_data", last_data, 16'h0018);
    check("post_rst_id", last_id, 1);
    check("post_rst_hs", hs_cnt, 1);
`ifdef CHT_SHIFT_SEQ_STATS_EN
    check("post_rst_stat", stat_cmds, 1);
`endif

    // Randomised commands with random consumer backpressure
    rdy_mode = 2;
    for (int i = 0; i < 24; i++) begin
      send($urandom_range(0, 1), 16'($urandom_range(0, 16'hFFFF)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
`ifdef CHT_SHIFT_SEQ_STATS_EN
    check("final_stat", stat_cmds, hs_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
